// File: rtl/home_pkg.sv
// Shared definitions for the home-automation sensor bus.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package home_pkg;

  // Temperature code presented to the automation controller on ST[1:0].
  localparam logic [1:0] ST_NORMAL = 2'b00;
  localparam logic [1:0] ST_COLD   = 2'b01;
  localparam logic [1:0] ST_HOT    = 2'b10;
  localparam logic [1:0] ST_FAULT  = 2'b11;

  // Temperature path: wait for a sample, then classify it on the next cycle.
  typedef enum logic {
    TS_IDLE,
    TS_CLASSIFY
  } temp_state_e;

endpackage

// File: rtl/debounce_cell.sv
// Synchronizes one raw contact and debounces it into a clean level.
// Latency: first edge sampling a new level is k, output moves at k+1+DEBOUNCE_CYCLES.
// Backpressure: none; the output is a free-running level.
// Ports: clk, rst (sync, active-low), raw_in (async contact), deb_out (clean level).
module debounce_cell #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic deb_out
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    out_d   = out_q;
    cnt_d   = '0;
    // Any cycle where the synchronized level agrees with the output restarts
    // the run; the output only flips after a full run of disagreeing cycles.
    if (sync2_q != out_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        out_d = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign deb_out = out_q;

endmodule

// File: rtl/sensor_frontend.sv
// Sensor bus producer: debounced contacts, sticky fire alarm, temperature code, change event.
// Latency: contacts k+1+DEBOUNCE_CYCLES, ST one edge after accept, evt one edge after any output change.
// Backpressure: temp_ready drops for the classify cycle; at most one sample per 2 cycles.
// Ports: clk, rst (sync, active-low); raw_fd/raw_rd/raw_w/raw_fa contacts; fa_clear;
//        temp_data/temp_valid/temp_ready sample handshake; SFD/SRD/SW/SFA levels; ST code; evt pulse.
module sensor_frontend
  import home_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TEMP_W          = 8,
  parameter int T_COLD          = 18,
  parameter int T_HOT           = 28,
  parameter int HYST            = 2,
  parameter int TIMEOUT         = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              raw_fd,
  input  logic              raw_rd,
  input  logic              raw_w,
  input  logic              raw_fa,
  input  logic              fa_clear,
  input  logic [TEMP_W-1:0] temp_data,
  input  logic              temp_valid,
  output logic              temp_ready,
  output logic              SFD,
  output logic              SRD,
  output logic              SW,
  output logic              SFA,
  output logic [1:0]        ST,
  output logic              evt
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  // Thresholds are held one bit wider than the sample so the hysteresis
  // offsets can neither overflow nor underflow.
  localparam logic [TEMP_W:0] COLD_LIM  = (TEMP_W + 1)'(T_COLD);
  localparam logic [TEMP_W:0] HOT_LIM   = (TEMP_W + 1)'(T_HOT);
  localparam logic [TEMP_W:0] COLD_EXIT = COLD_LIM + (TEMP_W + 1)'(HYST);
  localparam logic [TEMP_W:0] HOT_EXIT  = HOT_LIM - (TEMP_W + 1)'(HYST);

  function automatic logic [1:0] st_next(input logic [TEMP_W-1:0] smp,
                                         input logic [1:0]        cur);
    logic [TEMP_W:0] s;
    logic [1:0]      res;
    s   = {1'b0, smp};
    res = cur;
    case (cur)
      ST_COLD: begin
        if (s > HOT_LIM)         res = ST_HOT;
        else if (s >= COLD_EXIT) res = ST_NORMAL;
        else                     res = ST_COLD;
      end
      ST_HOT: begin
        if (s < COLD_LIM)        res = ST_COLD;
        else if (s <= HOT_EXIT)  res = ST_NORMAL;
        else                     res = ST_HOT;
      end
      default: begin
        // Normal and fault both reclassify from scratch.
        if (s < COLD_LIM)        res = ST_COLD;
        else if (s > HOT_LIM)    res = ST_HOT;
        else                     res = ST_NORMAL;
      end
    endcase
    return res;
  endfunction

  // ---------------- contact path ----------------
  logic sfd_deb, srd_deb, sw_deb, fa_deb;

  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_fd (
    .clk(clk), .rst(rst), .raw_in(raw_fd), .deb_out(sfd_deb));
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_rd (
    .clk(clk), .rst(rst), .raw_in(raw_rd), .deb_out(srd_deb));
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_w (
    .clk(clk), .rst(rst), .raw_in(raw_w), .deb_out(sw_deb));
  debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_fa (
    .clk(clk), .rst(rst), .raw_in(raw_fa), .deb_out(fa_deb));

  // Fire alarm latch: a high debounced level always (re)sets it, which also
  // makes a clear request coinciding with the level rising lose.
  logic sfa_q, sfa_d;

  always_comb begin
    sfa_d = sfa_q;
    if (fa_deb)        sfa_d = 1'b1;
    else if (fa_clear) sfa_d = 1'b0;
  end

  // ---------------- temperature path ----------------
  temp_state_e       state_q, state_d;
  logic [TEMP_W-1:0] sample_q, sample_d;
  logic [1:0]        st_q, st_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              accept;
  logic              wd_hit;

  // Ready is gated by reset so the source never sees an accept during reset.
  assign temp_ready = rst && (state_q == TS_IDLE);
  assign accept     = temp_valid && temp_ready;
  // The watchdog only fires on the cycle it would reach TIMEOUT, and an
  // accept on that same cycle takes precedence.
  assign wd_hit     = !accept && (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d = wd_q;
    if (accept)                     wd_d = '0;
    else if (wd_q != WD_W'(TIMEOUT)) wd_d = wd_q + WD_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    st_d     = st_q;
    case (state_q)
      TS_IDLE: begin
        if (accept) begin
          sample_d = temp_data;
          state_d  = TS_CLASSIFY;
        end else if (wd_hit) begin
          st_d = ST_FAULT;
        end
      end
      TS_CLASSIFY: begin
        st_d    = st_next(sample_q, st_q);
        state_d = TS_IDLE;
      end
      default: state_d = TS_IDLE;
    endcase
  end

  // ---------------- change event ----------------
  logic [5:0] out_vec;
  logic [5:0] prev_q, prev_d;
  logic       evt_q, evt_d;

  assign out_vec = {sfd_deb, srd_deb, sw_deb, sfa_q, st_q};

  always_comb begin
    prev_d = out_vec;
    evt_d  = (out_vec != prev_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sfa_q    <= 1'b0;
      state_q  <= TS_IDLE;
      sample_q <= '0;
      st_q     <= ST_NORMAL;
      wd_q     <= '0;
      prev_q   <= '0;
      evt_q    <= 1'b0;
    end else begin
      sfa_q    <= sfa_d;
      state_q  <= state_d;
      sample_q <= sample_d;
      st_q     <= st_d;
      wd_q     <= wd_d;
      prev_q   <= prev_d;
      evt_q    <= evt_d;
    end
  end

  assign SFD = sfd_deb;
  assign SRD = srd_deb;
  assign SW  = sw_deb;
  assign SFA = sfa_q;
  assign ST  = st_q;
  assign evt = evt_q;

endmodule

// File: tb/tb_sensor_frontend.sv
// Self-checking bench for sensor_frontend: directed test-plan items plus a
// randomized phase, all compared against a cycle-level reference model.
module tb_sensor_frontend;

  localparam int D  = 4;
  localparam int TW = 8;
  localparam int TC = 18;
  localparam int TH = 28;
  localparam int HY = 2;
  localparam int TO = 1000;
  localparam int HN = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          raw_fd, raw_rd, raw_w, raw_fa, fa_clear;
  logic [TW-1:0] temp_data;
  logic          temp_valid;
  logic          temp_ready;
  logic          SFD, SRD, SW, SFA, evt;
  logic [1:0]    ST;

  always #5 clk = ~clk;

  sensor_frontend #(
    .DEBOUNCE_CYCLES(D), .TEMP_W(TW), .T_COLD(TC), .T_HOT(TH), .HYST(HY), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa),
    .fa_clear(fa_clear),
    .temp_data(temp_data), .temp_valid(temp_valid), .temp_ready(temp_ready),
    .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST), .evt(evt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Contacts: the clean level moves at edge n when the raw samples taken at
  // edges n-1-D .. n-2 all agree on a value different from the current level.
  logic [3:0] hist [0:HN-1];   // raw samples per edge, bit0 fd, 1 rd, 2 w, 3 fa
  int         n = 0;           // edge counter
  logic [3:0] m_deb  = '0;
  logic       m_sfa  = 1'b0;
  logic [1:0] m_st   = 2'b00;
  logic       m_evt  = 1'b0;
  logic       m_idle = 1'b1;
  logic [7:0] m_pend = '0;
  int         m_last = 0;      // edge of last accept or reset
  logic [5:0] m_prev = '0;

  initial for (int i = 0; i < HN; i++) hist[i] = '0;

  function automatic logic [1:0] ref_class(input int s, input logic [1:0] cur);
    if (cur == 2'b01) return (s > TH) ? 2'b10 : (s >= TC + HY) ? 2'b00 : 2'b01;
    if (cur == 2'b10) return (s < TC) ? 2'b01 : (s <= TH - HY) ? 2'b00 : 2'b10;
    return (s < TC) ? 2'b01 : (s > TH) ? 2'b10 : 2'b00;
  endfunction

  task automatic model_edge();
    logic [3:0] deb_old;
    logic [5:0] cur;
    logic       acc;
    logic       v;
    bit         same;
    n++;
    if (!rst) begin
      m_deb = '0; m_sfa = 1'b0; m_st = 2'b00; m_evt = 1'b0;
      m_idle = 1'b1; m_prev = '0; m_last = n;
      hist[n % HN] = '0;
      hist[(n - 1) % HN] = '0;
    end else begin
      deb_old = m_deb;
      cur     = {m_deb[0], m_deb[1], m_deb[2], m_sfa, m_st};
      acc     = temp_valid && m_idle;
      m_evt   = (cur != m_prev);
      m_prev  = cur;
      if (n >= D + 1) begin
        for (int c = 0; c < 4; c++) begin
          v    = hist[(n - 1 - D) % HN][c];
          same = 1;
          for (int k = n - 1 - D; k <= n - 2; k++)
            if (hist[k % HN][c] != v) same = 0;
          if (same && v != deb_old[c]) m_deb[c] = v;
        end
      end
      if (deb_old[3])    m_sfa = 1'b1;
      else if (fa_clear) m_sfa = 1'b0;
      if (!m_idle) begin
        m_st   = ref_class(int'(m_pend), m_st);
        m_idle = 1'b1;
      end else if (acc) begin
        m_pend = temp_data;
        m_last = n;
        m_idle = 1'b0;
      end else if (n - m_last == TO) begin
        m_st = 2'b11;
      end
      hist[n % HN] = {raw_fa, raw_w, raw_rd, raw_fd};
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("outs", {24'd0, SFD, SRD, SW, SFA, ST, evt, temp_ready},
             {24'd0, m_deb[0], m_deb[1], m_deb[2], m_sfa, m_st, m_evt, rst & m_idle});
  endtask

  task automatic send_sample(input logic [7:0] v, input logic [1:0] exp, input string tag);
    bit got;
    got        = 0;
    temp_data  = v;
    temp_valid = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      got = temp_ready;
      step();
    end
    check_eq({tag, "_acc"}, got, 1);
    check_eq({tag, "_busy"}, temp_ready, 0);
    temp_valid = 1'b0;
    step();
    check_eq(tag, ST, exp);
  endtask

  logic [7:0] seq_v [7] = '{8'd25, 8'd15, 8'd19, 8'd20, 8'd30, 8'd27, 8'd26};
  logic [1:0] seq_e [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};

  initial begin
    bit got;
    rst = 1'b0; raw_fd = 0; raw_rd = 0; raw_w = 0; raw_fa = 0; fa_clear = 0;
    temp_data = '0; temp_valid = 0;

    // Reset
    repeat (3) step();
    check_eq("rst_outs", {SFD, SRD, SW, SFA, ST, evt}, 0);
    check_eq("rst_ready", temp_ready, 0);
    rst = 1'b1;
    step();
    check_eq("ready_after_rst", temp_ready, 1);

    // Front door debounce latency and single evt pulse
    raw_fd = 1'b1;
    for (int i = 1; i <= D + 4; i++) begin
      step();
      check_eq("sfd_lat", SFD, (i >= D + 2) ? 1 : 0);
      check_eq("sfd_evt", evt, (i == D + 3) ? 1 : 0);
    end

    // Short window glitch is filtered
    raw_w = 1'b1;
    repeat (3) step();
    raw_w = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_eq("glitch_sw", SW, 0);
      check_eq("glitch_evt", evt, 0);
    end

    // Temperature hysteresis sequence
    for (int i = 0; i < 7; i++) send_sample(seq_v[i], seq_e[i], "seq");

    // Sticky fire alarm
    raw_fa = 1'b1;
    repeat (10) step();
    fa_clear = 1'b1;
    step();
    fa_clear = 1'b0;
    check_eq("sfa_hold", SFA, 1);
    raw_fa = 1'b0;
    repeat (10) step();
    check_eq("sfa_sticky", SFA, 1);
    fa_clear = 1'b1;
    step();
    fa_clear = 1'b0;
    check_eq("sfa_clr", SFA, 0);

    // Watchdog timeout, then recovery
    for (int i = 0; i < 1100 && ST != 2'b11; i++) step();
    check_eq("wd_fault", ST, 2'b11);
    send_sample(8'd22, 2'b00, "wd_recover");

    // Valid held across classify: second sample waits for ready
    temp_data = 8'd30; temp_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      got = temp_ready;
      step();
    end
    check_eq("held_acc", got, 1);
    check_eq("held_busy", temp_ready, 0);
    temp_data = 8'd24;
    step();
    check_eq("held_st1", ST, 2'b10);
    check_eq("held_ready", temp_ready, 1);
    step();
    check_eq("held_busy2", temp_ready, 0);
    temp_valid = 1'b0;
    step();
    check_eq("held_st2", ST, 2'b00);

    // Reset during classify discards the pending sample
    send_sample(8'd35, 2'b10, "pre_rst");
    temp_data = 8'd40; temp_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      got = temp_ready;
      step();
    end
    check_eq("rst_cls_acc", got, 1);
    temp_valid = 1'b0;
    rst = 1'b0;
    step();
    check_eq("rst_cls_st", ST, 2'b00);
    check_eq("rst_cls_ready", temp_ready, 0);
    rst = 1'b1;
    step();
    check_eq("rel_ready", temp_ready, 1);
    step();
    check_eq("rel_st", ST, 2'b00);

    // Randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 5) == 0) raw_fd = ~raw_fd;
      if ($urandom_range(0, 5) == 0) raw_rd = ~raw_rd;
      if ($urandom_range(0, 5) == 0) raw_w  = ~raw_w;
      if ($urandom_range(0, 7) == 0) raw_fa = ~raw_fa;
      fa_clear = ($urandom_range(0, 15) == 0);
      if (!temp_valid || temp_ready) begin
        temp_valid = ($urandom_range(0, 2) == 0);
        temp_data  = 8'($urandom_range(0, 45));
      end
      if (!rst) rst = ($urandom_range(0, 1) == 0);
      else      rst = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_frontend.md
# sensor_frontend

Producer side of the home-automation sensor bus. Samples the raw door, window and fire-alarm contacts and a digital temperature sample stream. Produces the clean, debounced `SFD`/`SRD`/`SW`/`SFA` levels and the encoded `ST[1:0]` that the automation controller consumes every clock. Sits between the board-level sensor pins or ADC and the controller FSM.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a contact output changes; legal range ≥ 2.
- `TEMP_W`, default 8: width of the temperature sample in unsigned °C.
- `T_COLD`, default 18: cold threshold.
- `T_HOT`, default 28: hot threshold. Must be greater than `T_COLD + 2*HYST`.
- `HYST`, default 2: hysteresis band.
- `TIMEOUT`, default 1000: cycles without an accepted sample before the fault code is asserted.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `raw_fd`, `raw_rd`, `raw_w`, `raw_fa`  in  1 each  asynchronous raw contacts: front door, rear door, window, fire alarm.
- `fa_clear`  in  1  single-cycle request to clear the latched fire alarm.
- `temp_data`  in  TEMP_W  temperature sample.
- `temp_valid`  in  1  sample valid.
- `temp_ready`  out  1  sample accept.
- `SFD`, `SRD`, `SW`  out  1 each  debounced contact levels.
- `SFA`  out  1  latched fire alarm.
- `ST`  out  2  temperature code: 00 normal, 01 cold, 10 hot, 11 fault.
- `evt`  out  1  one-cycle pulse after any change on `SFD`/`SRD`/`SW`/`SFA`/`ST`.

## Operation
Contact path:
- Each raw contact passes through a 2-flop synchronizer, then a debounce counter.
- While the synchronized level differs from the output, the counter increments. Any cycle in which it matches clears the counter.
- When the counter has seen `DEBOUNCE_CYCLES` consecutive differing cycles, the output takes the new level and the counter clears.
- `SFA` is sticky. It sets when the debounced fire-alarm level rises.
- `SFA` clears only on `fa_clear`=1 while the debounced fire-alarm level is 0. `fa_clear` while the level is 1 is ignored.

Temperature path FSM:
- IDLE: `temp_ready`=1. On `temp_valid & temp_ready`, capture `temp_data`, clear the watchdog, go to CLASSIFY.
- CLASSIFY: `temp_ready`=0. Update `ST` from the captured sample and the previous `ST` (rules below), then return to IDLE.

`ST` update rules:
- From 00 or 11: sample < `T_COLD` gives 01; sample > `T_HOT` gives 10; otherwise 00.
- From 01: sample > `T_HOT` gives 10; sample ≥ `T_COLD+HYST` gives 00; otherwise stays 01.
- From 10: sample < `T_COLD` gives 01; sample ≤ `T_HOT-HYST` gives 00; otherwise stays 10.
- Comparisons are unsigned at `TEMP_W` bits. `T_COLD+HYST` and `T_HOT-HYST` are computed at `TEMP_W+1` bits, so there is no wrap.

Watchdog:
- Counts cycles without an accepted sample and saturates at `TIMEOUT`.
- On reaching `TIMEOUT`, `ST` becomes 11 and stays 11 until the next classified sample.
- An accept in the same cycle the count reaches `TIMEOUT` wins: the watchdog clears and `ST` is not forced to 11.

`evt` is registered. It pulses for exactly one cycle, the cycle after any output changes; it does not repeat while the outputs are stable.

## Timing
- Reset (`rst`=0 at an edge) sets `SFD`=`SRD`=`SW`=`SFA`=0, `ST`=00, `evt`=0. It also clears synchronizers, counters and watchdog, and puts the FSM in IDLE.
- `temp_ready`=0 while `rst`=0 and 1 in the first cycle after release.
- Contact latency: if edge k is the first edge that samples a new raw level, the output changes at edge k+1+`DEBOUNCE_CYCLES`.
  - A glitch lasting fewer than `DEBOUNCE_CYCLES` synchronized cycles produces no output change.
- Temperature latency: a sample accepted at edge a appears on `ST` at edge a+1. Throughput is at most one sample per 2 cycles.
- `temp_valid` during CLASSIFY is not accepted. The source must hold the sample until it sees `temp_ready`.
- A debounced fire-alarm rise in the same cycle as `fa_clear` leaves `SFA`=1.
- Reset asserted mid-debounce or in CLASSIFY abandons the operation: the captured sample is discarded and outputs return to reset values.

## Structure
- Shared package `home_pkg` holds:
  - ST code constants `ST_NORMAL`, `ST_COLD`, `ST_HOT`, `ST_FAULT`.
  - Temperature FSM state enum (`TS_IDLE`, `TS_CLASSIFY`).
- Sub-module `debounce_cell` (synchronizer, counter and output register, parameterized by `DEBOUNCE_CYCLES`) is instantiated four times.
- The `SFA` latch, temperature FSM and `evt` logic stay in the top level.

## Test plan
- Reset release, `raw_fd` held 1 from edge 10 → `SFD`=0 through edge 14, `SFD`=1 at edge 15 (`DEBOUNCE_CYCLES`=4), `evt`=1 for one cycle at edge 16.
- `raw_w` pulsed high for 3 cycles → `SW` stays 0, `evt` never pulses.
- Sample sequence 25, 15, 19, 20, 30, 27, 26 → `ST` = 00, 01, 01, 00, 10, 10, 00, each one edge after accept.
- `raw_fa` high 10 cycles then low, `fa_clear` pulsed while still high → `SFA` remains 1. `fa_clear` pulsed after debounced low → `SFA`=0 next edge.
- No `temp_valid` for 1000 cycles → `ST`=11. Then sample 22 → `ST`=00. `temp_valid` held during CLASSIFY → the second sample is accepted only after `temp_ready` returns.
- `rst`=0 asserted in CLASSIFY with a pending sample of 40 → `ST`=00, and `temp_ready`=1 the cycle after release.
